seq_chunk_adder: RTL and testbench
==================================

Name: seq_chunk_adder

Overview:
- Parametrised multi-cycle adder/subtractor, the successor to the fixed 4-bit ripple-carry adder.
- Adds two WIDTH-bit operands CHUNK bits per clock, keeping the carry in a register between chunks.
- Uses a start/busy/done handshake so wide datapaths (e.g. BCD/double-dabble correction stages) can trade latency for area.
- Adds a subtract mode plus carry-out and signed-overflow flags.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a positive multiple of CHUNK.
- CHUNK, 4, bits added per clock cycle; 1 <= CHUNK <= WIDTH.
- NCHUNK (localparam), WIDTH/CHUNK, number of add cycles per operation.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only while busy=0
- a  input  WIDTH  operand A, sampled on the accepting edge
- b  input  WIDTH  operand B, sampled on the accepting edge
- cin  input  1  carry-in; used only when sub=0
- sub  input  1  mode, sampled on the accepting edge; 0 = a+b+cin, 1 = a-b (a + ~b + 1, cin ignored)
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when result registers update
- sum  output  WIDTH  registered result
- cout  output  1  carry out of bit WIDTH-1; in sub mode 1 = no borrow (a >= b unsigned)
- ovf  output  1  two's-complement signed overflow of the full-width result

Behaviour:
- Reset (rst_n=0, immediate, independent of clk):
  - Outputs: busy=0, done=0, sum=0, cout=0, ovf=0.
  - Internal: chunk counter=0, carry reg=0, operand regs=0, FSM=IDLE.
  - Reset asserted mid-operation aborts the operation. No done pulse; no result update.
- FSM states: IDLE, RUN.
- IDLE:
  - Edge with start=1 latches a and b' (b' = sub ? ~b : b).
  - Loads carry = sub ? 1 : cin, counter=0, busy=1, then moves to RUN.
- RUN:
  - Each edge adds chunk k: a[k*CHUNK +: CHUNK] + b'[k*CHUNK +: CHUNK] + carry.
  - Writes the chunk result into the internal partial-sum register and the chunk carry-out into carry, then increments k.
  - On the edge processing k = NCHUNK-1:
    - sum <= full partial result; cout <= final carry.
    - ovf <= (a[MSB] == b'[MSB]) && (result[MSB] != a[MSB]).
    - done <= 1, busy <= 0, FSM -> IDLE.
- Latency:
  - Start accepted at edge E0; done=1 and the new sum are visible after edge E0+NCHUNK.
  - Example: 4 cycles for 16/4; 1 cycle when CHUNK=WIDTH.
- done is high for exactly one cycle and clears on the next edge unless that edge completes another operation.
- start while busy=0 and done=1 is accepted; back-to-back throughput is one result per NCHUNK+1 cycles.
- start while busy=1 is ignored. In-flight operands, mode and result are unaffected.
- sum/cout/ovf hold their values between completions. Changes to a, b, cin or sub after acceptance have no effect.
- Arithmetic wraps modulo 2^WIDTH. No internal state persists across operations except the held outputs.

Test Plan (WIDTH=16, CHUNK=4 unless noted):
- Add with carry: a=0x8A5F, b=0x1234, cin=1, sub=0, start pulse -> busy high 4 cycles; done pulse after edge 4; sum=0x9C94, cout=0, ovf=0.
- Signed overflow: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. Unsigned wrap: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0.
- Subtract: a=0x0005, b=0x0007, sub=1, cin=1 (must be ignored) -> sum=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
- Start while busy: start a=0x0001, b=0x0001; re-pulse start with a=0xFFFF, b=0xFFFF on cycle 2 -> single done, sum=0x0002. Start held high through done -> second operation accepted on the done cycle.
- Reset mid-operation: drive rst_n=0 for half a cycle during RUN cycle 2 -> busy, done, sum, cout and ovf all 0 immediately, no done pulse. Next start a=0x0003, b=0x0004 -> sum=0x0007 after 4 cycles.
- Parameter sweep: WIDTH=8, CHUNK=8, a=0xF0, b=0x10 -> done after 1 cycle, sum=0x00, cout=1. WIDTH=8, CHUNK=1, a=0x55, b=0xAB -> done after 8 cycles, sum=0x00, cout=1, ovf=0.

Source files
------------

// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor that processes CHUNK bits per clock and carries between chunks.
// Latency: start accepted at edge E0, done pulse and new result visible after edge E0+NCHUNK.
// Backpressure: start is ignored while busy; a new start is accepted on the cycle done is high.
// Ports: clk/rst_n (async active-low); start, a, b, cin, sub in; busy, done, sum, cout, ovf out.
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;       // shifts right one chunk per cycle
  logic [WIDTH-1:0] b_q;       // holds b' (b or ~b), shifts like a_q
  logic [WIDTH-1:0] part_q;    // chunk results shift in from the top
  logic             a_msb_q;   // operand sign bits kept for the overflow test
  logic             b_msb_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic [CHUNK:0]   csum_d;
  logic [WIDTH-1:0] part_d;
  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] b_d;
  logic [WIDTH-1:0] b_eff;
  logic             last_d;
  logic             ovf_d;

  always_comb begin
    // The low chunk of the shifting operand registers is always chunk k.
    csum_d = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
    // After NCHUNK shifts chunk 0 lands at the bottom of part_q.
    part_d = (part_q >> CHUNK) | (WIDTH'(csum_d[CHUNK-1:0]) << (WIDTH - CHUNK));
    a_d    = a_q >> CHUNK;
    b_d    = b_q >> CHUNK;
    b_eff  = sub ? ~b : b;
    last_d = (cnt_q == CW'(NCHUNK - 1));
    ovf_d  = (a_msb_q == b_msb_q) && (part_d[WIDTH-1] != a_msb_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b_eff;
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b_eff[WIDTH-1];
            carry_q <= sub ? 1'b1 : cin;
            part_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_d;
          b_q     <= b_d;
          part_q  <= part_d;
          carry_q <= csum_d[CHUNK];
          cnt_q   <= cnt_q + CW'(1);
          if (last_d) begin
            sum_q   <= part_d;
            cout_q  <= csum_d[CHUNK];
            ovf_q   <= ovf_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            // Clear per-operation state so nothing leaks into the next one.
            carry_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
module tb_seq_chunk_adder;

  localparam int N0 = 4;  // 16/4
  localparam int N1 = 1;  // 8/8
  localparam int N2 = 8;  // 8/1

  logic clk;
  logic rst_n;

  logic        start0, cin0, sub0, busy0, done0, cout0, ovf0;
  logic [15:0] a0, b0, sum0;
  logic        start1, cin1, sub1, busy1, done1, cout1, ovf1;
  logic [7:0]  a1, b1, sum1;
  logic        start2, cin2, sub2, busy2, done2, cout2, ovf2;
  logic [7:0]  a2, b2, sum2;

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_w16 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0), .cin(cin0), .sub(sub0),
    .busy(busy0), .done(done0), .sum(sum0), .cout(cout0), .ovf(ovf0));
  seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) u_w8c8 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1), .sub(sub1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1));
  seq_chunk_adder #(.WIDTH(8), .CHUNK(1)) u_w8c1 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2), .sub(sub2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2));

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t m0, m1, m2;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference: plain integer arithmetic on a w-bit word, signed overflow from true signed range.
  function automatic exp_t ref_op(input int w, input logic [15:0] a, input logic [15:0] b,
                                  input logic cin, input logic sub, input int due);
    exp_t   e;
    longint m, half, av, bv, full, sa, sb, r;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    av   = longint'(a) & m;
    bv   = longint'(b) & m;
    if (sub) begin
      full   = av - bv;
      e.cout = (av >= bv);
    end else begin
      full   = av + bv + longint'(cin);
      e.cout = ((full >> w) & 1) != 0;
    end
    e.sum = 16'(full & m);
    sa    = (av >= half) ? av - (m + 1) : av;
    sb    = (bv >= half) ? bv - (m + 1) : bv;
    r     = sub ? (sa - sb) : (sa + sb + longint'(cin));
    e.ovf = (r >= half) || (r < -half);
    e.due = due;
    return e;
  endfunction

  // Monitors: pop the scoreboard whenever a DUT presents done.
  always @(negedge clk) begin
    if (rst_n && done0) begin
      if (q0.size() == 0) check("w16 spurious done", 32'd1, 32'd0);
      else begin
        m0 = q0.pop_front();
        check("w16 result", {15'd0, sum0, cout0, ovf0}, {15'd0, m0.sum, m0.cout, m0.ovf});
        check("w16 latency", cyc, m0.due);
        check("w16 busy at done", {31'd0, busy0}, 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done1) begin
      if (q1.size() == 0) check("w8c8 spurious done", 32'd1, 32'd0);
      else begin
        m1 = q1.pop_front();
        check("w8c8 result", {23'd0, sum1, cout1, ovf1}, {15'd0, m1.sum, m1.cout, m1.ovf});
        check("w8c8 latency", cyc, m1.due);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done2) begin
      if (q2.size() == 0) check("w8c1 spurious done", 32'd1, 32'd0);
      else begin
        m2 = q2.pop_front();
        check("w8c1 result", {23'd0, sum2, cout2, ovf2}, {15'd0, m2.sum, m2.cout, m2.ovf});
        check("w8c1 latency", cyc, m2.due);
      end
    end
  end

  // Issue tasks are called just after a negedge; they return 1ns after the accepting edge
  // and scramble the inputs to show they are no longer observed.
  task automatic issue0(input logic [15:0] a, input logic [15:0] b, input logic c,
                        input logic s, input bit push);
    a0 = a; b0 = b; cin0 = c; sub0 = s; start0 = 1'b1;
    if (push) q0.push_back(ref_op(16, a, b, c, s, cyc + 1 + N0));
    @(posedge clk); #1;
    start0 = 1'b0; a0 = 16'($urandom); b0 = 16'($urandom);
    cin0 = 1'($urandom); sub0 = 1'($urandom);
    check("w16 busy after accept", {31'd0, busy0}, 32'd1);
  endtask

  task automatic issue1(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s);
    a1 = a; b1 = b; cin1 = c; sub1 = s; start1 = 1'b1;
    q1.push_back(ref_op(8, {8'd0, a}, {8'd0, b}, c, s, cyc + 1 + N1));
    @(posedge clk); #1;
    start1 = 1'b0; a1 = 8'($urandom); b1 = 8'($urandom);
    cin1 = 1'($urandom); sub1 = 1'($urandom);
  endtask

  task automatic issue2(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s);
    a2 = a; b2 = b; cin2 = c; sub2 = s; start2 = 1'b1;
    q2.push_back(ref_op(8, {8'd0, a}, {8'd0, b}, c, s, cyc + 1 + N2));
    @(posedge clk); #1;
    start2 = 1'b0; a2 = 8'($urandom); b2 = 8'($urandom);
    cin2 = 1'($urandom); sub2 = 1'($urandom);
  endtask

  function automatic logic busy_of(input int which);
    case (which)
      0:       return busy0;
      1:       return busy1;
      default: return busy2;
    endcase
  endfunction

  function automatic int qsize(input int which);
    case (which)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  // Returns just after a negedge at which the DUT is idle.
  task automatic wait_free(input int which);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy_of(which) && k < 60);
    if (busy_of(which)) check($sformatf("dut%0d busy timeout", which), 32'd1, 32'd0);
  endtask

  task automatic wait_drain(input int which);
    int k = 0;
    while (qsize(which) != 0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check($sformatf("dut%0d scoreboard drained", which), qsize(which), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start0 = 0; a0 = 0; b0 = 0; cin0 = 0; sub0 = 0;
    start1 = 0; a1 = 0; b1 = 0; cin1 = 0; sub1 = 0;
    start2 = 0; a2 = 0; b2 = 0; cin2 = 0; sub2 = 0;
    #1;
    check("w16 reset outputs", {11'd0, busy0, done0, sum0, cout0, ovf0}, 32'd0);
    check("w8c8 reset outputs", {19'd0, busy1, done1, sum1, cout1, ovf1}, 32'd0);
    check("w8c1 reset outputs", {19'd0, busy2, done2, sum2, cout2, ovf2}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Directed 16/4 cases
    wait_free(0); issue0(16'h8A5F, 16'h1234, 1'b1, 1'b0, 1'b1);
    wait_drain(0);
    check("w16 add example", {15'd0, sum0, cout0, ovf0}, {15'd0, 16'h9C94, 1'b0, 1'b0});
    wait_free(0); issue0(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    wait_drain(0);
    check("w16 signed ovf", {15'd0, sum0, cout0, ovf0}, {15'd0, 16'h8000, 1'b0, 1'b1});
    wait_free(0); issue0(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    wait_free(0); issue0(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1);
    wait_drain(0);
    check("w16 sub borrow", {15'd0, sum0, cout0, ovf0}, {15'd0, 16'hFFFE, 1'b0, 1'b0});
    wait_free(0); issue0(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
    wait_drain(0);
    check("w16 sub ovf", {15'd0, sum0, cout0, ovf0}, {15'd0, 16'h7FFF, 1'b1, 1'b1});

    // Start pulsed again while busy must be ignored
    wait_free(0); issue0(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    a0 = 16'hFFFF; b0 = 16'hFFFF; start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    wait_drain(0);
    repeat (6) @(negedge clk);
    check("w16 ignore start while busy", {16'd0, sum0}, 32'h0002);

    // Start held high through done: second op accepted on the done cycle
    wait_free(0);
    a0 = 16'h1234; b0 = 16'h1111; cin0 = 1'b0; sub0 = 1'b0; start0 = 1'b1;
    q0.push_back(ref_op(16, 16'h1234, 16'h1111, 1'b0, 1'b0, cyc + 1 + N0));
    @(posedge clk); #1;
    a0 = 16'h0003; b0 = 16'h0005; cin0 = 1'b1; sub0 = 1'b1;
    q0.push_back(ref_op(16, 16'h0003, 16'h0005, 1'b1, 1'b1, cyc + N0 + 1 + N0));
    repeat (N0 + 1) @(posedge clk);
    #1; start0 = 1'b0;
    wait_drain(0);

    // Reset in the middle of an operation
    wait_free(0); issue0(16'h4321, 16'h1111, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("w16 reset mid-op", {11'd0, busy0, done0, sum0, cout0, ovf0}, 32'd0);
    #4 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("w16 idle after abort", {31'd0, busy0}, 32'd0);
    issue0(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b1);
    wait_drain(0);
    check("w16 after reset", {15'd0, sum0, cout0, ovf0}, {15'd0, 16'h0007, 1'b0, 1'b0});

    // Random back-to-back traffic on 16/4
    for (int i = 0; i < 40; i++) begin
      wait_free(0);
      issue0(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    end
    wait_drain(0);

    // 8/8: single-cycle operation
    wait_free(1); issue1(8'hF0, 8'h10, 1'b0, 1'b0);
    wait_drain(1);
    check("w8c8 example", {23'd0, sum1, cout1, ovf1}, {23'd0, 8'h00, 1'b1, 1'b0});
    for (int i = 0; i < 20; i++) begin
      wait_free(1);
      issue1(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end
    wait_drain(1);

    // 8/1: bit-serial operation
    wait_free(2); issue2(8'h55, 8'hAB, 1'b0, 1'b0);
    wait_drain(2);
    check("w8c1 example", {23'd0, sum2, cout2, ovf2}, {23'd0, 8'h00, 1'b1, 1'b0});
    wait_free(2); issue2(8'h80, 8'h01, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      wait_free(2);
      issue2(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end
    wait_drain(2);

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
